// File: rtl/hist_frame_ctrl.sv
// hist_frame_ctrl: frame sequencer for hist_enhance (control packet, pixel gating, end-of-frame ack, timeout)
//   cfg_width/cfg_height/cfg_valid : pending frame size
//   start/cont                     : single-shot request / continuous mode
//   up_*                           : upstream pixel stream
//   ctl_*                          : enhancer control packet {width, height, 4'h0}
//   pix_*                          : gated pixel stream to enhancer sink
//   done_valid                     : enhancer end-of-frame acknowledge
//   busy/frame_done/frame_cnt/err  : status
module hist_frame_ctrl #(
  parameter int W = 512,
  parameter int H = 512,
  parameter int BITWIDTH = 18,
  parameter int TMO = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic        cfg_valid,
  input  logic        start,
  input  logic        cont,
  input  logic [7:0]  up_data,
  input  logic        up_valid,
  output logic        up_ready,
  output logic [35:0] ctl_data,
  output logic        ctl_valid,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  input  logic        done_valid,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, CFG, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [15:0] pw, ph, aw, ah, col, row;
  logic [31:0] tcnt, prod;
  logic [35:0] ctl_q;
  logic bad, xfer, last, tmo, col_end;
  always_comb begin
    prod = 32'(pw) * 32'(ph);
    bad = pw == '0 || ph == '0 || prod > (32'd1 << BITWIDTH);
    xfer = state == STREAM && up_valid && pix_ready;
    col_end = col == aw - 16'd1;
    last = xfer && col_end && row == ah - 16'd1;
    tmo = state == DRAIN && !done_valid && tcnt == 32'(TMO - 1);
    state_n = state == IDLE   ? (start ? CFG : IDLE) :
              state == CFG    ? (bad ? IDLE : STREAM) :
              state == STREAM ? (last ? DRAIN : STREAM) :
              done_valid      ? (cont ? CFG : IDLE) :
              tmo             ? IDLE : DRAIN;
    up_ready = state == STREAM && pix_ready;
    pix_valid = state == STREAM && up_valid;
    pix_data = up_data;
    ctl_valid = state == CFG && !bad;
    // the packet is live only during CFG; otherwise the last issued packet is held
    ctl_data = ctl_valid ? {pw, ph, 4'h0} : ctl_q;
    err = (state == CFG && bad) || tmo;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pw <= 16'(W);
      ph <= 16'(H);
      aw <= '0;
      ah <= '0;
      col <= '0;
      row <= '0;
      tcnt <= '0;
      ctl_q <= '0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      if (cfg_valid) begin
        pw <= cfg_width;
        ph <= cfg_height;
      end
      if (state == CFG) begin
        aw <= pw;
        ah <= ph;
        col <= '0;
        row <= '0;
      end else if (xfer) begin
        col <= col_end ? '0 : col + 16'd1;
        row <= col_end ? row + 16'd1 : row;
      end
      if (ctl_valid) ctl_q <= ctl_data;
      // zero everywhere outside DRAIN, so it starts from 0 on DRAIN entry
      tcnt <= state == DRAIN ? tcnt + 32'd1 : '0;
      frame_done <= state == DRAIN && done_valid;
      if (state == DRAIN && done_valid) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: doc/hist_frame_ctrl.md
# hist_frame_ctrl

Frame sequencer placed in front of `hist_enhance`. On a start request it issues the 36-bit control packet (width, height) to the enhancer, gates exactly width×height pixels from the upstream stream into the enhancer sink, then waits for the enhancer's `control_out_valid` as the end-of-frame acknowledge. It supports single-shot and continuous operation, run-time frame-size changes applied at frame boundaries, size checking and an acknowledge timeout.

## Interface
- `W`, 512, reset-default frame width
- `H`, 512, reset-default frame height
- `BITWIDTH`, 18, pixel-count limit: frames with width×height > 2^BITWIDTH are rejected
- `TMO`, 4096, DRAIN timeout in cycles
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `cfg_width`  in  16  new frame width
- `cfg_height`  in  16  new frame height
- `cfg_valid`  in  1  writes `cfg_width`/`cfg_height` into the pending-size registers
- `start`  in  1  request one frame; sampled only in IDLE
- `cont`  in  1  continuous mode; sampled at frame acknowledge
- `up_data`  in  8  upstream pixel
- `up_valid`  in  1  upstream pixel valid
- `up_ready`  out  1  upstream ready
- `ctl_data`  out  36  `{width[15:0], height[15:0], 4'h0}` to enhancer `control_in_data`
- `ctl_valid`  out  1  to enhancer `control_in_valid`
- `pix_data`  out  8  to enhancer `sink_data`
- `pix_valid`  out  1  to enhancer `sink_valid`
- `pix_ready`  in  1  from enhancer `sink_ready`
- `done_valid`  in  1  from enhancer `control_out_valid`
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse per acknowledged frame
- `frame_cnt`  out  16  acknowledged-frame count, wraps
- `err`  out  1  one-cycle pulse: invalid size or timeout

## Operation
- Pending size `pw`/`ph` resets to `W`/`H`. `cfg_valid` loads them in any state.
- Active size `aw`/`ah` is loaded from `pw`/`ph` on leaving CFG. Mid-frame config changes therefore apply only to the next frame.
- States:
  - IDLE: `start`=1 → CFG.
  - CFG (exactly 1 cycle):
    - If `pw`=0, `ph`=0 or `pw`×`ph` > 2^BITWIDTH (32-bit product): `err` pulse → IDLE.
    - Otherwise: `ctl_valid`=1, `ctl_data`={`pw`,`ph`,4'h0}, column/row counters cleared → STREAM.
  - STREAM:
    - `pix_valid` = `up_valid`; `up_ready` = `pix_ready`; `pix_data` = `up_data` (combinational).
    - A transfer occurs when `up_valid` & `pix_ready` are both high.
    - Each transfer increments the column counter. At `aw`−1 the column counter wraps to 0 and the row counter increments.
    - A transfer at (col=`aw`−1, row=`ah`−1) → DRAIN.
  - DRAIN:
    - `up_ready`=0, `pix_valid`=0. Timeout counter cleared on entry.
    - `done_valid` → `frame_done` pulse, `frame_cnt`+1, then go to CFG if `cont`=1, else IDLE.
    - Counter reaching `TMO`−1 without `done_valid` → `err` pulse → IDLE (`frame_cnt` unchanged).
- Outside STREAM: `up_ready`=0, `pix_valid`=0, `pix_data`=`up_data`.
- Ignored events:
  - `start` outside IDLE.
  - `done_valid` outside DRAIN.
  - `cont` except at the acknowledge.
- `cfg_valid` in the same cycle as `start` is used by that frame, because CFG reads `pw`/`ph` one cycle later.

## Timing
- Reset values: `up_ready`=0, `ctl_valid`=0, `ctl_data`=0, `pix_valid`=0, `busy`=0, `frame_done`=0, `frame_cnt`=0, `err`=0, state IDLE, `pw`/`ph`=`W`/`H`.
- Reset mid-frame: all state clears immediately (asynchronous); the partial frame is abandoned.
- Latencies:
  - `start` at cycle n → `ctl_valid` at n+1 → first transfer possible at n+2.
  - Last transfer at cycle m → `up_ready`=0 from m+1.
  - `done_valid` at cycle k → `frame_done` and incremented `frame_cnt` visible at k+1.
  - In continuous mode, the next `ctl_valid` follows at k+1.
- `ctl_data` holds its last value between packets.
- The pass-through path adds zero latency. The block never accepts more than `aw`×`ah` pixels per frame.

## Test plan
- Basic frame: cfg 4×2, `start`, `up_valid` and `pix_ready` held high → one `ctl_valid` with `ctl_data`=0x000400020; exactly 8 transfers; `up_ready` low afterwards; `done_valid` → `frame_done`, `frame_cnt`=1, `busy`=0.
- Backpressure: 4×2 with `pix_ready` toggling every cycle and `up_valid` random → still exactly 8 transfers; data matches upstream order; no transfer while `pix_ready`=0.
- Continuous and config change: `cont`=1 at 4×2; `cfg_valid` 2×2 during frame 1 → frame 1 takes 8 pixels; frame 2 has `ctl_data`=0x000200020 and takes 4 pixels; `frame_cnt`=2.
- Invalid size: cfg 0×8, `start` → `err` pulse at cycle n+1, no `ctl_valid`, IDLE. Cfg 1024×512 with `BITWIDTH`=18 → `err` pulse.
- Timeout: `TMO`=16, frame completes, `done_valid` withheld → `err` exactly 16 cycles after DRAIN entry; `frame_cnt` unchanged. Subsequent `start` works normally.
- Reset mid-STREAM after 3 of 8 pixels → all outputs at reset values. A new `start` produces a full 8-pixel frame.
